// File: rtl/packet_framer.sv
// ---------------------------------------------------------------------------
// packet_framer
//
// Takes 16-bit sensor samples and sends each one to a byte-wide radio as a
// six-byte frame:
//   PREAMBLE, NODE_ID, seq, sample[15:8], sample[7:0], CHK
// CHK is the XOR of bytes 1..4.
//
// Each byte follows the same handshake. The block pulses `send` with the byte
// on `tx_data`. It then waits for the radio to raise `busy`, and after that
// for `busy` to fall. If `busy` does not rise within TIMEOUT cycles of the
// send pulse, the frame is dropped and `tx_error` pulses.
//
// A one-entry holding buffer sits in front of the framer. While a frame is
// being sent, the next sample can wait in this buffer.
//
// Ports
//   clk           single clock, rising edge
//   rst           synchronous active-high reset
//   enable        permits a new frame to start (sampled only in IDLE)
//   sample_valid  upstream sample offered
//   sample_data   16-bit sample
//   sample_ready  holding buffer can take a sample this cycle
//   send          one-cycle transmit request to the radio
//   tx_data       byte presented to the radio
//   busy          radio is transmitting
//   frame_done    one-cycle pulse when a whole frame has been sent
//   tx_error      one-cycle pulse when busy never rose after a send
//   seq_num       sequence number the next completed frame will carry
// ---------------------------------------------------------------------------
module packet_framer #(
  parameter logic [7:0]  NODE_ID  = 8'h01,
  parameter logic [7:0]  PREAMBLE = 8'hA5,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  output logic        sample_ready,
  output logic        send,
  output logic [7:0]  tx_data,
  input  logic        busy,
  output logic        frame_done,
  output logic        tx_error,
  output logic [7:0]  seq_num
);

  // The counter only has to reach TIMEOUT-1, so it needs clog2(TIMEOUT) bits.
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [2:0] LAST_IDX = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT_START,
    ST_WAIT_DONE,
    ST_NEXT
  } state_t;

  state_t            state_reg, state_next;
  logic [2:0]        idx_reg, idx_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [7:0]        tx_data_reg, tx_data_next;
  logic [7:0]        seq_reg, seq_next;
  logic [7:0]        frame_seq_reg, frame_seq_next;
  logic [15:0]       frame_sample_reg, frame_sample_next;
  logic              hold_full_reg, hold_full_next;
  logic [15:0]       hold_data_reg, hold_data_next;
  logic              sample_accept;

  // Selects one byte of the frame.
  // Callers pass the index as a function input rather than a register, so
  // LOAD and NEXT can select the byte that is about to be presented.
  function automatic logic [7:0] frame_byte(
    input logic [2:0]  idx,
    input logic [7:0]  seq,
    input logic [15:0] smp
  );
    logic [7:0] b;
    case (idx)
      3'd0:    b = PREAMBLE;
      3'd1:    b = NODE_ID;
      3'd2:    b = seq;
      3'd3:    b = smp[15:8];
      3'd4:    b = smp[7:0];
      default: b = NODE_ID ^ seq ^ smp[15:8] ^ smp[7:0];
    endcase
    return b;
  endfunction

  // In LOAD the buffer's content moves into the frame register. The slot is
  // therefore free in that cycle, and a sample offered then is taken
  // straight away, which keeps the buffer full without a gap.
  assign sample_ready  = !hold_full_reg || (state_reg == ST_LOAD);
  assign sample_accept = sample_valid && sample_ready;

  assign tx_data = tx_data_reg;
  assign seq_num = seq_reg;

  // Next-state and output logic
  always_comb begin
    state_next        = state_reg;
    idx_next          = idx_reg;
    cnt_next          = cnt_reg;
    tx_data_next      = tx_data_reg;
    seq_next          = seq_reg;
    frame_seq_next    = frame_seq_reg;
    frame_sample_next = frame_sample_reg;
    hold_full_next    = hold_full_reg;
    hold_data_next    = hold_data_reg;
    send              = 1'b0;
    frame_done        = 1'b0;
    tx_error          = 1'b0;

    // Holding buffer
    if (sample_accept) begin
      hold_data_next = sample_data;
      hold_full_next = 1'b1;
    end else if (state_reg == ST_LOAD) begin
      hold_full_next = 1'b0;
    end

    case (state_reg)
      ST_IDLE: begin
        // busy is deliberately ignored here.
        if (enable && hold_full_reg) begin
          state_next = ST_LOAD;
        end
      end

      ST_LOAD: begin
        frame_sample_next = hold_data_reg;
        frame_seq_next    = seq_reg;
        idx_next          = 3'd0;
        tx_data_next      = frame_byte(3'd0, seq_reg, hold_data_reg);
        state_next        = ST_ISSUE;
      end

      ST_ISSUE: begin
        send       = 1'b1;
        cnt_next   = '0;
        state_next = ST_WAIT_START;
      end

      ST_WAIT_START: begin
        if (busy) begin
          state_next = ST_WAIT_DONE;
        end else if (cnt_reg == CNT_LAST) begin
          // The error pulse comes TIMEOUT cycles after the send pulse. The
          // frame is dropped and seq_reg is left unchanged.
          tx_error   = 1'b1;
          cnt_next   = '0;
          idx_next   = 3'd0;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      ST_WAIT_DONE: begin
        // No timeout here: the radio decides how long a byte takes.
        if (!busy) begin
          state_next = ST_NEXT;
        end
      end

      ST_NEXT: begin
        if (idx_reg == LAST_IDX) begin
          frame_done = 1'b1;
          seq_next   = seq_reg + 8'd1;   // wraps FF -> 00 naturally
          idx_next   = 3'd0;
          state_next = ST_IDLE;
        end else begin
          idx_next     = idx_reg + 3'd1;
          tx_data_next = frame_byte(idx_reg + 3'd1, frame_seq_reg,
                                    frame_sample_reg);
          state_next   = ST_ISSUE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      idx_reg          <= 3'd0;
      cnt_reg          <= '0;
      tx_data_reg      <= 8'h00;
      seq_reg          <= 8'h00;
      frame_seq_reg    <= 8'h00;
      frame_sample_reg <= 16'h0000;
      hold_full_reg    <= 1'b0;
      hold_data_reg    <= 16'h0000;
    end else begin
      state_reg        <= state_next;
      idx_reg          <= idx_next;
      cnt_reg          <= cnt_next;
      tx_data_reg      <= tx_data_next;
      seq_reg          <= seq_next;
      frame_seq_reg    <= frame_seq_next;
      frame_sample_reg <= frame_sample_next;
      hold_full_reg    <= hold_full_next;
      hold_data_reg    <= hold_data_next;
    end
  end

endmodule

// File: doc/packet_framer.md
PACKET_FRAMER -- requirements
Module: packet_framer

Interface
REQ-001 Parameter NODE_ID, default 8'h01: node identifier inserted as frame byte 1.
REQ-002 Parameter PREAMBLE, default 8'hA5: frame byte 0.
REQ-003 Parameter TIMEOUT, default 16: maximum cycles the block waits for radio busy to rise after a send pulse.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  when low, no new frame starts; a frame in progress completes.
REQ-007 sample_valid  in  1  upstream sample offered.
REQ-008 sample_data  in  16  sensor sample.
REQ-009 sample_ready  out  1  high when the holding buffer is empty; a sample transfers when valid and ready are both high.
REQ-010 send  out  1  one-cycle pulse to the radio requesting transmission of tx_data.
REQ-011 tx_data  out  8  byte presented to the radio.
REQ-012 busy  in  1  radio transmitting.
REQ-013 frame_done  out  1  one-cycle pulse after the last byte's busy falls.
REQ-014 tx_error  out  1  one-cycle pulse on a busy timeout.
REQ-015 seq_num  out  8  sequence number of the next frame.

Function
REQ-016 Frame: 6 bytes in order: PREAMBLE, NODE_ID, seq_num, sample[15:8], sample[7:0], CHK.
REQ-017 CHK is the XOR of bytes 1 through 4.
REQ-018 Holding buffer: one 16-bit entry plus a full flag; sample_ready = !full.
REQ-019 The buffer accepts a new sample during an active frame, giving one-deep double buffering.
REQ-020 States: IDLE, LOAD, ISSUE, WAIT_START, WAIT_DONE, NEXT.
REQ-021 IDLE: when enable=1 and the buffer is full, go to LOAD.
REQ-022 LOAD: copy the buffer into a frame register, clear full, latch seq_num, set byte index to 0, then go to ISSUE.
REQ-023 If sample_valid is high in the same cycle as LOAD, the new sample is accepted and full stays set.
REQ-024 ISSUE: send=1 for exactly one cycle, then go to WAIT_START.
REQ-025 tx_data holds the indexed byte from ISSUE through WAIT_DONE and changes only in NEXT or LOAD.
REQ-026 WAIT_START: when busy=1, go to WAIT_DONE.
REQ-027 WAIT_START: if busy stays 0 for TIMEOUT cycles, pulse tx_error, discard the frame, leave seq_num unchanged, and go to IDLE.
REQ-028 WAIT_DONE: when busy=0, go to NEXT.
REQ-029 WAIT_DONE has no timeout.
REQ-030 NEXT: if index<5, increment the index and go to ISSUE.
REQ-031 NEXT: if index=5, pulse frame_done, increment seq_num (mod 256, 8'hFF wraps to 8'h00), and go to IDLE.
REQ-032 Minimum spacing between send pulses is 4 cycles: ISSUE, WAIT_START, WAIT_DONE, NEXT.
REQ-033 enable is sampled only in IDLE.
REQ-034 busy=1 seen in IDLE is ignored.

Reset
REQ-035 rst=1 at any clock edge, including mid-frame, forces: state IDLE, send=0, tx_data=8'h00, frame_done=0, tx_error=0, seq_num=8'h00, buffer full=0 (sample_ready=1), index=0, timeout counter=0.
REQ-036 A frame interrupted by reset is not resumed.

Verification
REQ-037 Single frame: enable=1, sample 16'h1234, radio model raises busy 1 cycle after send and holds it 10 cycles -> tx_data sequence A5,01,00,12,34,27; exactly 6 send pulses; one frame_done; seq_num=01.
REQ-038 Back-to-back: sample 16'hBEEF offered during frame 0 -> accepted mid-frame; frame 1 bytes A5,01,01,BE,EF,51; seq_num=02.
REQ-039 Backpressure: buffer full plus a frame active -> sample_ready=0; a third sample is held by upstream without loss, then sent as frame 2.
REQ-040 Timeout: busy tied 0 -> tx_error pulses 16 cycles after the first send; no frame_done; seq_num unchanged; next sample sends normally.
REQ-041 Reset mid-frame: rst asserted in WAIT_DONE of byte 3 -> next cycle send=0, seq_num=00, sample_ready=1; the next frame starts with byte A5.
REQ-042 Wrap and enable: preload 255 frames -> seq_num wraps FF to 00; enable=0 with buffer full -> no send pulse until enable=1.
